// File: rtl/charrom_pkg.sv
// charrom_pkg: shared widths, host FSM state type and the ROM address helper
// for the character-ROM arbiter.
//   CODE_W/ROW_W/ADDR_W/DATA_W : glyph code, scanline, ROM address, ROM data widths
//   ROW_MAX                    : last populated glyph scanline
//   host_state_e               : host read FSM states
//   charrom_addr()             : {row, code} -> ROM address (128 bytes per scanline)
package charrom_pkg;

  localparam int unsigned CODE_W  = 7;
  localparam int unsigned ROW_W   = 4;
  localparam int unsigned ADDR_W  = 11;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ROW_MAX = 8;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_PEND,
    HS_RD,
    HS_RESP
  } host_state_e;

  function automatic logic [ADDR_W-1:0] charrom_addr(input logic [CODE_W-1:0] code,
                                                     input logic [ROW_W-1:0]  row);
    return {row, code};
  endfunction

endpackage

// File: rtl/charrom_host_port.sv
// charrom_host_port: host readback FSM (IDLE/PEND/RD/RESP), request capture,
// response register and starvation counter/flag.
//   clk, reset                     : clock, synchronous active-high reset
//   host_req_valid/ready, code/row : host request handshake and glyph address
//   host_rsp_valid/ready/data      : host response handshake and glyph byte
//   host_starved                   : sticky flag, set after STARVE_LIMIT lost slots
//   vid_busy                       : video owns the ROM this cycle
//   rom_dout                       : ROM read data
//   host_rom_req, host_addr        : host wants the ROM this cycle, and where
// Optional macro CHARROM_ARB_ROWCLAMP_EN: rows above ROW_MAX skip the ROM and read 0.
module charrom_host_port
  import charrom_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 1023,
  parameter int unsigned CNT_W        = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic [CODE_W-1:0] host_code,
  input  logic [ROW_W-1:0]  host_row,
  output logic              host_rsp_valid,
  input  logic              host_rsp_ready,
  output logic [DATA_W-1:0] host_rsp_data,
  output logic              host_starved,
  input  logic              vid_busy,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              host_rom_req,
  output logic [ADDR_W-1:0] host_addr
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);

  host_state_e       state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              starved_q, starved_d;
  logic              ready_q, ready_d;
  logic              row_clamp;

`ifdef CHARROM_ARB_ROWCLAMP_EN
  assign row_clamp = row_q > ROW_W'(ROW_MAX);
`else
  assign row_clamp = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      HS_IDLE: begin
        if (host_req_valid) begin
          code_d  = host_code;
          row_d   = host_row;
          cnt_d   = '0;
          state_d = HS_PEND;
        end
      end
      HS_PEND: begin
        // A clamped row needs no ROM slot, so it never waits on video.
        if (row_clamp || !vid_busy) begin
          state_d = HS_RD;
        end else if (cnt_q != LIM) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HS_RD: begin
        rsp_data_d = row_clamp ? '0 : rom_dout;
        state_d    = HS_RESP;
      end
      HS_RESP: begin
        if (host_rsp_ready) state_d = HS_IDLE;
      end
      default: state_d = HS_IDLE;
    endcase
    starved_d   = starved_q | ((state_q == HS_PEND) && (cnt_d == LIM));
    rsp_valid_d = (state_d == HS_RESP);
    ready_d     = (state_d == HS_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HS_IDLE;
      code_q      <= '0;
      row_q       <= '0;
      cnt_q       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      starved_q   <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      starved_q   <= starved_d;
      ready_q     <= ready_d;
    end
  end

  // ready_q comes out of reset set; gating with reset keeps it low while reset is held.
  assign host_req_ready = ready_q & ~reset;
  assign host_rsp_valid = rsp_valid_q;
  assign host_rsp_data  = rsp_data_q;
  assign host_starved   = starved_q;
  assign host_rom_req   = (state_q == HS_PEND) && !vid_busy && !row_clamp;
  assign host_addr      = charrom_addr(code_q, row_q);

endmodule

// File: rtl/charrom_arbiter.sv
// charrom_arbiter: shares the single-port 2048x8 glyph ROM between the video
// pipeline (absolute priority, fixed 2-cycle latency) and a host readback port.
//   clk, reset                        : clock, synchronous active-high reset
//   vid_req, vid_code, vid_row        : video fetch request (never stalled)
//   vid_valid, vid_data               : video glyph byte, 2 cycles after vid_req
//   host_req_* / host_rsp_* / host_*  : host request/response handshake
//   host_starved                      : sticky starvation flag
//   rom_ce, rom_oce, rom_reset, rom_ad, rom_dout : ROM control and data pins
// Optional macro CHARROM_ARB_ROWCLAMP_EN: rows above ROW_MAX read 8'h00 without a ROM access.
module charrom_arbiter
  import charrom_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 1023,
  parameter int unsigned CNT_W        = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [CODE_W-1:0] vid_code,
  input  logic [ROW_W-1:0]  vid_row,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic [CODE_W-1:0] host_code,
  input  logic [ROW_W-1:0]  host_row,
  output logic              host_rsp_valid,
  input  logic              host_rsp_ready,
  output logic [DATA_W-1:0] host_rsp_data,
  output logic              host_starved,
  output logic              rom_ce,
  output logic              rom_oce,
  output logic              rom_reset,
  output logic [ADDR_W-1:0] rom_ad,
  input  logic [DATA_W-1:0] rom_dout
);

  logic              vid_clamp, vid_grant;
  logic              host_rom_req;
  logic [ADDR_W-1:0] host_addr;

  logic              v1_q, v1_d;
  logic              clamp1_q, clamp1_d;
  logic              vid_valid_q, vid_valid_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;
  logic [ADDR_W-1:0] last_ad_q, last_ad_d;

`ifdef CHARROM_ARB_ROWCLAMP_EN
  assign vid_clamp = vid_row > ROW_W'(ROW_MAX);
`else
  assign vid_clamp = 1'b0;
`endif

  assign vid_grant = vid_req & ~vid_clamp;

  charrom_host_port #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_host (
    .clk           (clk),
    .reset         (reset),
    .host_req_valid(host_req_valid),
    .host_req_ready(host_req_ready),
    .host_code     (host_code),
    .host_row      (host_row),
    .host_rsp_valid(host_rsp_valid),
    .host_rsp_ready(host_rsp_ready),
    .host_rsp_data (host_rsp_data),
    .host_starved  (host_starved),
    .vid_busy      (vid_req),
    .rom_dout      (rom_dout),
    .host_rom_req  (host_rom_req),
    .host_addr     (host_addr)
  );

  // Grant mux: video first, host only in idle video cycles; the address bus
  // keeps its last driven value when nobody is granted.
  always_comb begin
    rom_ce = 1'b0;
    rom_ad = last_ad_q;
    if (vid_grant) begin
      rom_ce = 1'b1;
      rom_ad = charrom_addr(vid_code, vid_row);
    end else if (host_rom_req) begin
      rom_ce = 1'b1;
      rom_ad = host_addr;
    end
    if (reset) begin
      rom_ce = 1'b0;
      rom_ad = '0;
    end
    last_ad_d = rom_ad;
  end

  // Video pipeline: stage 1 marks the ROM access, stage 2 registers rom_dout.
  always_comb begin
    v1_d        = vid_req;
    clamp1_d    = vid_req & vid_clamp;
    vid_valid_d = v1_q;
    vid_data_d  = vid_data_q;
    if (v1_q) vid_data_d = clamp1_q ? '0 : rom_dout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q        <= 1'b0;
      clamp1_q    <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
      last_ad_q   <= '0;
    end else begin
      v1_q        <= v1_d;
      clamp1_q    <= clamp1_d;
      vid_valid_q <= vid_valid_d;
      vid_data_q  <= vid_data_d;
      last_ad_q   <= last_ad_d;
    end
  end

  assign vid_valid = vid_valid_q;
  assign vid_data  = vid_data_q;
  assign rom_oce   = 1'b1;
  assign rom_reset = reset;

endmodule

// File: tb/tb_charrom_arbiter.sv
module tb_charrom_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        vid_req;
  logic [6:0]  vid_code;
  logic [3:0]  vid_row;
  logic        vid_valid;
  logic [7:0]  vid_data;
  logic        host_req_valid;
  logic        host_req_ready;
  logic [6:0]  host_code;
  logic [3:0]  host_row;
  logic        host_rsp_valid;
  logic        host_rsp_ready;
  logic [7:0]  host_rsp_data;
  logic        host_starved;
  logic        rom_ce;
  logic        rom_oce;
  logic        rom_reset;
  logic [10:0] rom_ad;
  logic [7:0]  rom_dout = 8'h00;

  int n_vec = 0;
  int n_err = 0;

  charrom_arbiter #(
    .STARVE_LIMIT(8),
    .CNT_W       (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .vid_req       (vid_req),
    .vid_code      (vid_code),
    .vid_row       (vid_row),
    .vid_valid     (vid_valid),
    .vid_data      (vid_data),
    .host_req_valid(host_req_valid),
    .host_req_ready(host_req_ready),
    .host_code     (host_code),
    .host_row      (host_row),
    .host_rsp_valid(host_rsp_valid),
    .host_rsp_ready(host_rsp_ready),
    .host_rsp_data (host_rsp_data),
    .host_starved  (host_starved),
    .rom_ce        (rom_ce),
    .rom_oce       (rom_oce),
    .rom_reset     (rom_reset),
    .rom_ad        (rom_ad),
    .rom_dout      (rom_dout)
  );

  always #5 clk = ~clk;

  // Glyph ROM content: byte = addr[7:0] ^ {1, addr[10:8], 4'h5}.
  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    return a[7:0] ^ {1'b1, a[10:8], 4'h5};
  endfunction

  always @(posedge clk) if (rom_ce) rom_dout <= rom_fn(rom_ad);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    vid_req = 1'b1; vid_code = 7'h41; vid_row = 4'd2;
    repeat (3) tick();
    #1;
    n_vec++; if (rom_ce !== 1'b0) begin n_err++; $display("FAIL rst_rom_ce: got %b exp 0", rom_ce); end
    n_vec++; if (rom_ad !== 11'h000) begin n_err++; $display("FAIL rst_rom_ad: got %h exp 000", rom_ad); end
    n_vec++; if (vid_valid !== 1'b0) begin n_err++; $display("FAIL rst_vid_valid: got %b exp 0", vid_valid); end
    n_vec++; if (vid_data !== 8'h00) begin n_err++; $display("FAIL rst_vid_data: got %h exp 00", vid_data); end
    n_vec++; if (host_req_ready !== 1'b0) begin n_err++; $display("FAIL rst_req_ready: got %b exp 0", host_req_ready); end
    n_vec++; if (host_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b exp 0", host_rsp_valid); end
    n_vec++; if (host_rsp_data !== 8'h00) begin n_err++; $display("FAIL rst_rsp_data: got %h exp 00", host_rsp_data); end
    n_vec++; if (host_starved !== 1'b0) begin n_err++; $display("FAIL rst_starved: got %b exp 0", host_starved); end
    n_vec++; if (rom_reset !== 1'b1) begin n_err++; $display("FAIL rst_rom_reset: got %b exp 1", rom_reset); end
    n_vec++; if (rom_oce !== 1'b1) begin n_err++; $display("FAIL rom_oce: got %b exp 1", rom_oce); end
    reset = 1'b0;
    vid_req = 1'b0;
    #1;
    n_vec++; if (host_req_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %b exp 1", host_req_ready); end
    n_vec++; if (rom_reset !== 1'b0) begin n_err++; $display("FAIL post_rst_rom_reset: got %b exp 0", rom_reset); end
  endtask

  task automatic test_video();
    tick();
    vid_req = 1'b1; vid_code = 7'h41; vid_row = 4'd2;
    #1;
    n_vec++; if (rom_ce !== 1'b1) begin n_err++; $display("FAIL vid_ce: got %b exp 1", rom_ce); end
    n_vec++; if (rom_ad !== 11'h141) begin n_err++; $display("FAIL vid_ad: got %h exp 141", rom_ad); end
    tick();
    vid_req = 1'b0;
    #1;
    n_vec++; if (vid_valid !== 1'b0) begin n_err++; $display("FAIL vid_valid_n1: got %b exp 0", vid_valid); end
    n_vec++; if (rom_ce !== 1'b0) begin n_err++; $display("FAIL vid_ce_idle: got %b exp 0", rom_ce); end
    n_vec++; if (rom_ad !== 11'h141) begin n_err++; $display("FAIL vid_ad_hold: got %h exp 141", rom_ad); end
    tick();
    #1;
    n_vec++; if (vid_valid !== 1'b1) begin n_err++; $display("FAIL vid_valid_n2: got %b exp 1", vid_valid); end
    n_vec++; if (vid_data !== 8'hD4) begin n_err++; $display("FAIL vid_data_n2: got %h exp d4", vid_data); end
    tick();
    #1;
    n_vec++; if (vid_valid !== 1'b0) begin n_err++; $display("FAIL vid_valid_n3: got %b exp 0", vid_valid); end
  endtask

  task automatic test_host_basic();
    tick();
    host_req_valid = 1'b1; host_code = 7'h30; host_row = 4'd0;
    #1;
    n_vec++; if (host_req_ready !== 1'b1) begin n_err++; $display("FAIL hb_ready_n: got %b exp 1", host_req_ready); end
    tick();
    host_req_valid = 1'b0;
    #1;
    n_vec++; if (rom_ce !== 1'b1) begin n_err++; $display("FAIL hb_ce_n1: got %b exp 1", rom_ce); end
    n_vec++; if (rom_ad !== 11'h030) begin n_err++; $display("FAIL hb_ad_n1: got %h exp 030", rom_ad); end
    n_vec++; if (host_req_ready !== 1'b0) begin n_err++; $display("FAIL hb_ready_n1: got %b exp 0", host_req_ready); end
    tick();
    #1;
    n_vec++; if (host_rsp_valid !== 1'b0) begin n_err++; $display("FAIL hb_valid_n2: got %b exp 0", host_rsp_valid); end
    n_vec++; if (rom_ce !== 1'b0) begin n_err++; $display("FAIL hb_ce_n2: got %b exp 0", rom_ce); end
    tick();
    #1;
    n_vec++; if (host_rsp_valid !== 1'b1) begin n_err++; $display("FAIL hb_valid_n3: got %b exp 1", host_rsp_valid); end
    n_vec++; if (host_rsp_data !== 8'hB5) begin n_err++; $display("FAIL hb_data_n3: got %h exp b5", host_rsp_data); end
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      n_vec++; if (host_rsp_valid !== 1'b1) begin n_err++; $display("FAIL hb_hold_valid[%0d]: got %b exp 1", i, host_rsp_valid); end
      n_vec++; if (host_rsp_data !== 8'hB5) begin n_err++; $display("FAIL hb_hold_data[%0d]: got %h exp b5", i, host_rsp_data); end
      n_vec++; if (host_req_ready !== 1'b0) begin n_err++; $display("FAIL hb_hold_ready[%0d]: got %b exp 0", i, host_req_ready); end
    end
    host_rsp_ready = 1'b1;
    tick();
    host_rsp_ready = 1'b0;
    #1;
    n_vec++; if (host_rsp_valid !== 1'b0) begin n_err++; $display("FAIL hb_consumed_valid: got %b exp 0", host_rsp_valid); end
    n_vec++; if (host_req_ready !== 1'b1) begin n_err++; $display("FAIL hb_consumed_ready: got %b exp 1", host_req_ready); end
  endtask

  task automatic test_host_stall();
    logic [10:0] va [20];
    tick();
    host_req_valid = 1'b1; host_code = 7'h05; host_row = 4'd3;
    #1;
    tick();
    host_req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      vid_req = 1'b1; vid_code = 7'(i); vid_row = 4'(i % 9);
      va[i] = {4'(i % 9), 7'(i)};
      #1;
      n_vec++; if (rom_ad !== va[i]) begin n_err++; $display("FAIL st_ad[%0d]: got %h exp %h", i, rom_ad, va[i]); end
      n_vec++; if (host_rsp_valid !== 1'b0) begin n_err++; $display("FAIL st_rsp_early[%0d]: got %b exp 0", i, host_rsp_valid); end
      if (i >= 2) begin
        n_vec++; if (vid_valid !== 1'b1 || vid_data !== rom_fn(va[i-2]))
          begin n_err++; $display("FAIL st_vid[%0d]: got %b/%h exp 1/%h", i, vid_valid, vid_data, rom_fn(va[i-2])); end
      end
      tick();
    end
    vid_req = 1'b0;
    #1;
    n_vec++; if (rom_ce !== 1'b1 || rom_ad !== 11'h185) begin n_err++; $display("FAIL st_host_slot: got %b/%h exp 1/185", rom_ce, rom_ad); end
    n_vec++; if (vid_valid !== 1'b1 || vid_data !== rom_fn(va[18]))
      begin n_err++; $display("FAIL st_vid_tail18: got %b/%h exp 1/%h", vid_valid, vid_data, rom_fn(va[18])); end
    tick();
    #1;
    n_vec++; if (vid_valid !== 1'b1 || vid_data !== rom_fn(va[19]))
      begin n_err++; $display("FAIL st_vid_tail19: got %b/%h exp 1/%h", vid_valid, vid_data, rom_fn(va[19])); end
    n_vec++; if (host_rsp_valid !== 1'b0) begin n_err++; $display("FAIL st_rsp_n22: got %b exp 0", host_rsp_valid); end
    tick();
    #1;
    n_vec++; if (host_rsp_valid !== 1'b1) begin n_err++; $display("FAIL st_rsp_n23: got %b exp 1", host_rsp_valid); end
    n_vec++; if (host_rsp_data !== rom_fn(11'h185)) begin n_err++; $display("FAIL st_rsp_data: got %h exp %h", host_rsp_data, rom_fn(11'h185)); end
    n_vec++; if (host_starved !== 1'b1) begin n_err++; $display("FAIL st_starved: got %b exp 1", host_starved); end
    host_rsp_ready = 1'b1;
    tick();
    host_rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_rd();
    tick();
    host_req_valid = 1'b1; host_code = 7'h10; host_row = 4'd1;
    #1;
    tick();
    host_req_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    #1;
    n_vec++; if (host_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rr_rsp_valid: got %b exp 0", host_rsp_valid); end
    n_vec++; if (host_starved !== 1'b0) begin n_err++; $display("FAIL rr_starved: got %b exp 0", host_starved); end
    reset = 1'b0;
    #1;
    n_vec++; if (host_req_ready !== 1'b1) begin n_err++; $display("FAIL rr_idle_ready: got %b exp 1", host_req_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      n_vec++; if (host_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rr_stale[%0d]: got %b exp 0", i, host_rsp_valid); end
    end
  endtask

  task automatic test_starvation();
    tick();
    host_req_valid = 1'b1; host_code = 7'h7F; host_row = 4'd8;
    #1;
    tick();
    host_req_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      vid_req = 1'b1; vid_code = 7'h01; vid_row = 4'd1;
      #1;
      n_vec++; if (host_starved !== (i >= 8)) begin n_err++; $display("FAIL sv_flag[%0d]: got %b exp %b", i, host_starved, (i >= 8)); end
      tick();
    end
    vid_req = 1'b0;
    #1;
    n_vec++; if (rom_ce !== 1'b1 || rom_ad !== 11'h47F) begin n_err++; $display("FAIL sv_slot: got %b/%h exp 1/47f", rom_ce, rom_ad); end
    tick();
    tick();
    #1;
    n_vec++; if (host_rsp_valid !== 1'b1 || host_rsp_data !== rom_fn(11'h47F))
      begin n_err++; $display("FAIL sv_rsp: got %b/%h exp 1/%h", host_rsp_valid, host_rsp_data, rom_fn(11'h47F)); end
    host_rsp_ready = 1'b1;
    tick();
    host_rsp_ready = 1'b0;
    #1;
    n_vec++; if (host_starved !== 1'b1) begin n_err++; $display("FAIL sv_sticky: got %b exp 1", host_starved); end
  endtask

  task automatic test_rowclamp();
`ifdef CHARROM_ARB_ROWCLAMP_EN
    tick();
    vid_req = 1'b1; vid_code = 7'h22; vid_row = 4'd12;
    #1;
    n_vec++; if (rom_ce !== 1'b0) begin n_err++; $display("FAIL rc_vid_ce: got %b exp 0", rom_ce); end
    tick();
    vid_req = 1'b0;
    tick();
    #1;
    n_vec++; if (vid_valid !== 1'b1 || vid_data !== 8'h00) begin n_err++; $display("FAIL rc_vid_data: got %b/%h exp 1/00", vid_valid, vid_data); end
    tick();
    host_req_valid = 1'b1; host_code = 7'h11; host_row = 4'd15;
    vid_req = 1'b1; vid_code = 7'h03; vid_row = 4'd4;
    #1;
    tick();
    host_req_valid = 1'b0;
    #1;
    n_vec++; if (rom_ad !== 11'h203) begin n_err++; $display("FAIL rc_host_ad: got %h exp 203", rom_ad); end
    tick();
    tick();
    #1;
    n_vec++; if (host_rsp_valid !== 1'b1 || host_rsp_data !== 8'h00)
      begin n_err++; $display("FAIL rc_host_rsp: got %b/%h exp 1/00", host_rsp_valid, host_rsp_data); end
    vid_req = 1'b0;
    host_rsp_ready = 1'b1;
    tick();
    host_rsp_ready = 1'b0;
`else
    tick();
    vid_req = 1'b1; vid_code = 7'h22; vid_row = 4'd12;
    #1;
    n_vec++; if (rom_ce !== 1'b1 || rom_ad !== 11'h622) begin n_err++; $display("FAIL hr_vid_ce: got %b/%h exp 1/622", rom_ce, rom_ad); end
    tick();
    vid_req = 1'b0;
    tick();
    #1;
    n_vec++; if (vid_valid !== 1'b1 || vid_data !== rom_fn(11'h622))
      begin n_err++; $display("FAIL hr_vid_data: got %b/%h exp 1/%h", vid_valid, vid_data, rom_fn(11'h622)); end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    vid_req = 1'b0; vid_code = '0; vid_row = '0;
    host_req_valid = 1'b0; host_code = '0; host_row = '0;
    host_rsp_ready = 1'b0;
    test_reset();
    test_video();
    test_host_basic();
    test_host_stall();
    test_reset_mid_rd();
    test_starvation();
    test_rowclamp();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/charrom_arbiter.md
# charrom_arbiter

Shares the single-port 2048x8 character-glyph ROM between the VGA scanline pixel pipeline and a host readback port. The video requester has absolute priority and a fixed two-cycle data latency. Host reads run only in cycles where video is idle. The block sits between the text-mode video generator and the `charROM` instance, and it drives all ROM control pins.

## Interface
Parameters:
- `STARVE_LIMIT`, 1023: count of consecutive host-pending cycles, without a ROM slot, at which `host_starved` sets.
- `CNT_W`, 10: width of the starvation counter. `2**CNT_W` must be greater than `STARVE_LIMIT`.

Ports:
- `clk` in 1: single clock for the block and the ROM.
- `reset` in 1: synchronous, active-high.
- `vid_req` in 1: video fetch request, one per cycle, never stalled.
- `vid_code` in 7: character code.
- `vid_row` in 4: glyph scanline.
- `vid_valid` out 1: video data valid.
- `vid_data` out 8: glyph byte for the video pipeline.
- `host_req_valid` in 1: host request valid.
- `host_req_ready` out 1: host request accepted when high together with valid.
- `host_code` in 7: host character code.
- `host_row` in 4: host glyph scanline.
- `host_rsp_valid` out 1: host response valid.
- `host_rsp_ready` in 1: host consumes the response.
- `host_rsp_data` out 8: host glyph byte.
- `host_starved` out 1: sticky starvation flag.
- `rom_ce` out 1: ROM clock enable.
- `rom_oce` out 1: ROM output clock enable. Tied to 1.
- `rom_reset` out 1: ROM reset. Equals `reset`.
- `rom_ad` out 11: ROM address.
- `rom_dout` in 8: ROM read data, valid one cycle after a `rom_ce` cycle.

## Operation
- ROM address is `{row[3:0], code[6:0]}`: one 128-byte block per glyph scanline. Glyph rows 0..8 are populated.
- **Video path** (combinational grant):
  - `vid_req`=1 → `rom_ce`=1 and `rom_ad={vid_row,vid_code}` in the same cycle.
  - A one-bit valid shift register of depth 2 marks the request.
  - `rom_dout` is registered into `vid_data` with `vid_valid`=1.
- **Host FSM** (states IDLE, PEND, RD, RESP):
  - IDLE: `host_req_ready`=1. On `host_req_valid`, capture code and row → PEND.
  - PEND: if `vid_req`=0, drive `rom_ce`=1 with the captured address → RD. Otherwise stay in PEND and increment the wait counter.
  - RD: capture `rom_dout` into `host_rsp_data` → RESP.
  - RESP: `host_rsp_valid`=1. On `host_rsp_ready` → IDLE. Data and valid stay stable until consumed.
  - One host transaction is outstanding at a time. `host_req_ready`=0 in every state except IDLE.
- **Starvation**:
  - The wait counter clears on entry to PEND and saturates at `STARVE_LIMIT`.
  - Reaching `STARVE_LIMIT` sets `host_starved`, which holds until reset.
  - Video keeps priority even while starved.
- **Simultaneous events**: if `vid_req` and a host slot coincide in PEND, video wins and the host waits. Video never observes host activity.
- **Reset mid-operation**: the FSM returns to IDLE, the in-flight host read and video valids are discarded, and the counter and flag clear.
- **Reset values**: `vid_valid`=0, `vid_data`=0, `host_req_ready`=0 during reset and 1 from the first cycle after, `host_rsp_valid`=0, `host_rsp_data`=0, `host_starved`=0, `rom_ce`=0, `rom_ad`=0.

## Timing
- Video latency is fixed at 2: `vid_req` in cycle N gives `vid_valid`/`vid_data` in cycle N+2. Back-to-back requests give back-to-back data.
- Host minimum latency: accept in cycle N, ROM access in N+1, capture in N+2, `host_rsp_valid` in N+3.
- Each cycle with `vid_req`=1 in PEND delays the host response by exactly one cycle.
- Host throughput is at most one read per 4 cycles, because IDLE→PEND→RD→RESP→IDLE.
- `rom_ce` is asserted only in granted cycles. `rom_ad` holds its last value otherwise.

## Configuration
`CHARROM_ARB_ROWCLAMP_EN`:
- Defined: a row greater than 8 from either requester returns 8'h00 with no ROM access and `rom_ce`=0.
  - Video: latency is still 2.
  - Host: moves PEND→RD without waiting for a slot, and `host_rsp_data`=0.
- Undefined: all 16 rows read the ROM unchanged.

## Structure
- Package `charrom_pkg` holds:
  - `CODE_W`=7, `ROW_W`=4, `ADDR_W`=11, `DATA_W`=8, `ROW_MAX`=8.
  - The host FSM state enum.
  - A `charrom_addr` function for address concatenation.
- Sub-module `charrom_host_port` contains the host FSM, capture registers and starvation counter. The top level holds the grant mux and the video pipeline.

## Test plan
- Reset, then `vid_req` pulse with code 7'h41, row 2 → `rom_ad`=11'h141 in cycle N, `vid_valid` with the ROM byte at that address in cycle N+2. All outputs are 0 during reset.
- Host reads code 7'h30, row 0 with video idle → `host_rsp_valid` in cycle N+3 with byte at address 11'h030. `host_rsp_ready` held low for 5 cycles → data stable and `host_req_ready`=0 throughout.
- Host pending while `vid_req`=1 for 20 cycles → no host `rom_ce` during those cycles, response 20 cycles later than minimum, video data uninterrupted.
- `STARVE_LIMIT`=8 with continuous `vid_req` and a pending host read → `host_starved` rises after 8 wait cycles and stays set after video stops and the host completes.
- `reset` asserted while in RD → next cycle IDLE, `host_rsp_valid`=0, `host_starved`=0, no stale response afterwards.
- With `CHARROM_ARB_ROWCLAMP_EN`, video row 12 → `rom_ce`=0 and `vid_data`=8'h00 at N+2. Host row 15 → response 8'h00 despite continuous `vid_req`.
